heap_sift_down: RTL and testbench

Sequential, parametrised sift-down engine for the HeapSort datapath. It generalises the single-step two-index element swap into a multi-level heapify: it loads a flat vector of DEPTH signed elements and, starting from a given root, performs one compare-and-swap level per clock until the heap property holds below that root. It returns the updated vector and a swap count. The HeapSort controller uses it for both heap build (root = n/2-1 … 0) and extract-max (root 0, shrinking size).

---
 rtl/heap_sift_down.sv | 132 +++++++++++++
 tb/tb_heap_sift_down.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/heap_sift_down.sv
// Multi-level heap sift-down engine: loads a vector, then does one compare-and-swap level per clock.
// Optional HEAP_SIFT_MIN_EN selects min-heap ordering (smallest element rises); default is max-heap.
module heap_sift_down #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int IDXW  = $clog2(DEPTH + 1)
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     start_i,
  input  logic [WIDTH*DEPTH-1:0]   vec_i,
  input  logic [IDXW-1:0]          root_i,
  input  logic [IDXW-1:0]          size_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH*DEPTH-1:0]   vec_o,
  output logic [IDXW-1:0]          swaps_o
);

  // Handshake: start_i is a request pulse taken only in IDLE (never queued);
  // busy_o is high for every SIFT cycle and done_o pulses for exactly one cycle afterwards.
  typedef enum logic [1:0] {S_IDLE, S_SIFT, S_DONE} state_e;

  // Child indices get two extra bits so 2*cur+2 cannot wrap even for an out-of-range root.
  localparam int CW = IDXW + 2;

  state_e                   state_q, state_d;
  logic signed [WIDTH-1:0]  vec_q [DEPTH];
  logic signed [WIDTH-1:0]  vec_d [DEPTH];
  logic [IDXW-1:0]          cur_q, cur_d;
  logic [IDXW-1:0]          sz_q, sz_d;
  logic [IDXW-1:0]          swaps_q, swaps_d;

  logic [CW-1:0]            l_idx, r_idx, sel_idx, sz_ext, cur_ext;
  logic                     l_part, r_part;
  logic signed [WIDTH-1:0]  cur_val, l_val, r_val, sel_val;

  function automatic logic wins(input logic signed [WIDTH-1:0] a,
                                input logic signed [WIDTH-1:0] b);
`ifdef HEAP_SIFT_MIN_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  always_comb begin
    cur_ext = CW'(cur_q);
    sz_ext  = CW'(sz_q);
    l_idx   = {1'b0, cur_q, 1'b0} + CW'(1);
    r_idx   = {1'b0, cur_q, 1'b0} + CW'(2);
    l_part  = l_idx < sz_ext;
    r_part  = r_idx < sz_ext;
    cur_val = '0;
    l_val   = '0;
    r_val   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cur_ext == CW'(i)) cur_val = vec_q[i];
      if (l_idx == CW'(i))   l_val   = vec_q[i];
      if (r_idx == CW'(i))   r_val   = vec_q[i];
    end
    // Strict comparisons: ties keep the parent, and an equal right child cannot beat the left.
    sel_idx = cur_ext;
    sel_val = cur_val;
    if (l_part && wins(l_val, sel_val)) begin
      sel_idx = l_idx;
      sel_val = l_val;
    end
    if (r_part && wins(r_val, sel_val)) begin
      sel_idx = r_idx;
      sel_val = r_val;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sz_d    = sz_q;
    swaps_d = swaps_q;
    for (int i = 0; i < DEPTH; i++) vec_d[i] = vec_q[i];
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int i = 0; i < DEPTH; i++) vec_d[i] = vec_i[(DEPTH-1-i)*WIDTH +: WIDTH];
          cur_d   = root_i;
          sz_d    = (size_i > IDXW'(DEPTH)) ? IDXW'(DEPTH) : size_i;
          swaps_d = '0;
          state_d = S_SIFT;
        end
      end
      S_SIFT: begin
        if (sel_idx != cur_ext) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (cur_ext == CW'(i)) vec_d[i] = sel_val;
            if (sel_idx == CW'(i)) vec_d[i] = cur_val;
          end
          cur_d   = sel_idx[IDXW-1:0];
          swaps_d = swaps_q + IDXW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      sz_q    <= '0;
      swaps_q <= '0;
      for (int i = 0; i < DEPTH; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      sz_q    <= sz_d;
      swaps_q <= swaps_d;
      for (int i = 0; i < DEPTH; i++) vec_q[i] <= vec_d[i];
    end
  end

  assign busy_o  = (state_q == S_SIFT);
  assign done_o  = (state_q == S_DONE);
  assign swaps_o = swaps_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign vec_o[(DEPTH-1-g)*WIDTH +: WIDTH] = vec_q[g];
  end

endmodule

// File: tb/tb_heap_sift_down.sv
// Directed and random checks of heap_sift_down (WIDTH=32, DEPTH=5) with an expected-result queue.
module tb_heap_sift_down;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int IDXW  = $clog2(DEPTH + 1);
  localparam int PW    = WIDTH * DEPTH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [PW-1:0]   vec_i = '0;
  logic [IDXW-1:0] root_i = '0;
  logic [IDXW-1:0] size_i = '0;
  logic            busy_o, done_o;
  logic [PW-1:0]   vec_o;
  logic [IDXW-1:0] swaps_o;

  int n_vec  = 0;
  int n_fail = 0;

  logic [PW-1:0] exp_q[$];
  int            exp_sw_q[$];

  heap_sift_down #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .start_i        (start_i),
    .vec_i          (vec_i),
    .root_i         (root_i),
    .size_i         (size_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .vec_o          (vec_o),
    .swaps_o        (swaps_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input int a[DEPTH]);
    logic [PW-1:0] p;
    for (int i = 0; i < DEPTH; i++) p[(DEPTH-1-i)*WIDTH +: WIDTH] = a[i];
    return p;
  endfunction

  // Reference sift-down on plain ints.
  task automatic model(input logic [PW-1:0] v, input int root, input int size,
                       output logic [PW-1:0] vo, output int sw);
    int a[DEPTH];
    int sz, cur, best, l, r, t;
    for (int i = 0; i < DEPTH; i++) a[i] = $signed(v[(DEPTH-1-i)*WIDTH +: WIDTH]);
    sz  = (size > DEPTH) ? DEPTH : size;
    cur = root;
    sw  = 0;
    forever begin
      l = 2 * cur + 1;
      r = 2 * cur + 2;
      best = cur;
`ifdef HEAP_SIFT_MIN_EN
      if (l < sz && a[l] < a[best]) best = l;
      if (r < sz && a[r] < a[best]) best = r;
`else
      if (l < sz && a[l] > a[best]) best = l;
      if (r < sz && a[r] > a[best]) best = r;
`endif
      if (best == cur) break;
      t = a[cur]; a[cur] = a[best]; a[best] = t;
      cur = best;
      sw++;
    end
    vo = pack(a);
  endtask

  task automatic push_exp(input logic [PW-1:0] v, input int sw);
    exp_q.push_back(v);
    exp_sw_q.push_back(sw);
  endtask

  // driver: one operation, checked against the head of the scoreboard
  task automatic run_op(input string tag, input logic [PW-1:0] v, input int root,
                        input int size, input bit hold);
    int c, busy_cnt, done_cyc, done_cnt, sw;
    logic [PW-1:0] ev;
    vec_i   = v;
    root_i  = IDXW'(root);
    size_i  = IDXW'(size);
    start_i = 1'b1;
    tick();
    if (!hold) start_i = 1'b0;
    c = 1; busy_cnt = 0; done_cyc = 0; done_cnt = 0;
    while (c <= 12 && done_cyc == 0) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cyc = c;
        done_cnt++;
      end else begin
        tick();
        c++;
      end
    end
    start_i = 1'b0;
    if (done_cyc == 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL %s_timeout: observed no done_o expected done_o within 12 cycles", tag);
      void'(exp_q.pop_front());
      void'(exp_sw_q.pop_front());
      return;
    end
    ev = exp_q.pop_front();
    sw = exp_sw_q.pop_front();
    chk({tag, "_vec"},   vec_o, ev);
    chk({tag, "_swaps"}, PW'(swaps_o), PW'(sw));
    chk({tag, "_lat"},   PW'(done_cyc), PW'(sw + 2));
    chk({tag, "_busy"},  PW'(busy_cnt), PW'(sw + 1));
    tick();
    if (done_o) done_cnt++;
    chk({tag, "_pulse"}, PW'(done_cnt), PW'(1));
    chk({tag, "_idle"},  PW'(busy_o), PW'(0));
    chk({tag, "_hold"},  vec_o, ev);
  endtask

  initial begin
    logic [PW-1:0] v, ev;
    int sw, root, size;
    int a[DEPTH];

    tick();
    tick();
    chk("rst_vec",   vec_o, '0);
    chk("rst_swaps", PW'(swaps_o), '0);
    chk("rst_busy",  PW'(busy_o), '0);
    chk("rst_done",  PW'(done_o), '0);
    rst = 1'b0;
    tick();

`ifdef HEAP_SIFT_MIN_EN
    push_exp(pack('{1, 3, 8, 9, 4}), 2);
    run_op("min_two", pack('{9, 1, 8, 3, 4}), 0, 5, 1'b0);
`else
    push_exp(pack('{9, 4, 8, 3, 1}), 2);
    run_op("two_swaps", pack('{1, 9, 8, 3, 4}), 0, 5, 1'b0);

    push_exp(pack('{1, 2, 3, 4, 5}), 0);
    run_op("root_beyond", pack('{1, 2, 3, 4, 5}), 4, 4, 1'b0);

    push_exp(pack('{-1, -5, -7, 0, 0}), 1);
    run_op("signed_size", pack('{-5, -1, -7, 0, 0}), 0, 3, 1'b0);

    push_exp(pack('{5, 5, 5, 0, 0}), 0);
    run_op("ties_clamp", pack('{5, 5, 5, 0, 0}), 0, 7, 1'b1);

    // left and right children equal: left wins
    push_exp(pack('{7, 2, 7, 0, 0}), 1);
    run_op("left_wins", pack('{2, 7, 7, 0, 0}), 0, 5, 1'b0);

    // abort with reset during SIFT, then rerun
    vec_i   = pack('{1, 9, 8, 3, 4});
    root_i  = '0;
    size_i  = IDXW'(5);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("abort_busy_before", PW'(busy_o), PW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  PW'(busy_o), '0);
    chk("abort_done",  PW'(done_o), '0);
    chk("abort_vec",   vec_o, '0);
    chk("abort_swaps", PW'(swaps_o), '0);
    push_exp(pack('{9, 4, 8, 3, 1}), 2);
    run_op("rerun", pack('{1, 9, 8, 3, 4}), 0, 5, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) a[i] = int'($urandom_range(0, 20)) - 10;
      v    = pack(a);
      root = int'($urandom_range(0, 4));
      size = int'($urandom_range(0, 7));
      model(v, root, size, ev, sw);
      push_exp(ev, sw);
      run_op("random", v, root, size, 1'b0);
    end

    chk("sb_empty", PW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
